// File: rtl/wasca_led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : wasca_led_sequencer
//  Description : Avalon-MM LED controller with per-LED direct, blink, activity
//                pulse-stretch and blink-while-active modes.
//                Optional global PWM brightness when LED_SEQ_PWM_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module wasca_led_sequencer #(
    parameter int NUM_LEDS       = 5,
    parameter int PRESCALE_RESET = 49999,
    parameter int BLINK_TICKS    = 250,
    parameter int STRETCH_RESET  = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic [NUM_LEDS-1:0] act_in,
    output logic [NUM_LEDS-1:0] out_port
);

    localparam int                 BLINK_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_ACT    = 2'b10;

    logic [NUM_LEDS-1:0]        direct_q,    direct_d;
    logic [2*NUM_LEDS-1:0]      mode_q,      mode_d;
    logic [15:0]                prescale_q,  prescale_d;
    logic [7:0]                 stretch_q,   stretch_d;
    logic [15:0]                tick_cnt_q,  tick_cnt_d;
    logic [BLINK_W-1:0]         blink_cnt_q, blink_cnt_d;
    logic                       phase_q,     phase_d;
    logic [NUM_LEDS-1:0]        sync1_q,     sync1_d;
    logic [NUM_LEDS-1:0]        sync2_q,     sync2_d;
    logic [NUM_LEDS-1:0]        prev_q,      prev_d;
    logic [NUM_LEDS-1:0][7:0]   act_cnt_q,   act_cnt_d;
    logic [NUM_LEDS-1:0]        out_q,       out_d;

    logic                       wr_en;
    logic                       prescale_wr;
    logic                       tick;
    logic [NUM_LEDS-1:0]        act_edge;
    logic [NUM_LEDS-1:0]        active;
    logic [NUM_LEDS-1:0]        composite;
    logic                       unused_wdata;

`ifdef LED_SEQ_PWM_EN
    logic [7:0]                 bright_q,    bright_d;
    logic [7:0]                 pwm_cnt_q,   pwm_cnt_d;
    logic [NUM_LEDS-1:0]        comp_q,      comp_d;
    logic                       pwm_gate;
`endif

    assign unused_wdata = ^writedata;

    // Register file
    always_comb begin
        wr_en       = chipselect && !write_n;
        prescale_wr = wr_en && (address == 2'd2);
        direct_d    = direct_q;
        mode_d      = mode_q;
        prescale_d  = prescale_q;
        stretch_d   = stretch_q;
`ifdef LED_SEQ_PWM_EN
        bright_d    = bright_q;
`endif
        if (wr_en) begin
            case (address)
                2'd0: direct_d = writedata[NUM_LEDS-1:0];
                2'd1: mode_d   = writedata[2*NUM_LEDS-1:0];
                2'd2: begin
                    prescale_d = writedata[15:0];
`ifdef LED_SEQ_PWM_EN
                    bright_d   = writedata[23:16];
`endif
                end
                default: stretch_d = writedata[7:0];
            endcase
        end
    end

    // A PRESCALE write restarts the period and suppresses that cycle's tick
    always_comb begin
        tick       = (tick_cnt_q == 16'd0) && !prescale_wr;
        tick_cnt_d = tick_cnt_q - 16'd1;
        if (prescale_wr) begin
            tick_cnt_d = writedata[15:0];
        end else if (tick_cnt_q == 16'd0) begin
            tick_cnt_d = prescale_q;
        end

        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        sync1_d   = act_in;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        act_edge  = sync2_q & ~prev_q;
        act_cnt_d = act_cnt_q;
        active    = '0;
        composite = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            // A fresh edge reloads even when a tick lands in the same cycle
            if (act_edge[i] && (stretch_q != 8'd0)) begin
                act_cnt_d[i] = stretch_q;
            end else if (tick && (act_cnt_q[i] != 8'd0)) begin
                act_cnt_d[i] = act_cnt_q[i] - 8'd1;
            end
            active[i] = (act_cnt_q[i] != 8'd0);
            case (mode_q[2*i +: 2])
                MODE_DIRECT: composite[i] = direct_q[i];
                MODE_BLINK:  composite[i] = direct_q[i] & phase_q;
                MODE_ACT:    composite[i] = direct_q[i] | active[i];
                default:     composite[i] = active[i] ? phase_q : direct_q[i];
            endcase
        end
    end

`ifdef LED_SEQ_PWM_EN
    always_comb begin
        comp_d    = composite;
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        pwm_gate  = (bright_q == 8'hFF) || (pwm_cnt_q < bright_q);
        out_d     = comp_q & {NUM_LEDS{pwm_gate}};
    end
`else
    always_comb begin
        out_d = composite;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            direct_q    <= '0;
            mode_q      <= '0;
            prescale_q  <= 16'(PRESCALE_RESET);
            stretch_q   <= 8'(STRETCH_RESET);
            tick_cnt_q  <= 16'(PRESCALE_RESET);
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            act_cnt_q   <= '0;
            out_q       <= '0;
        end else begin
            direct_q    <= direct_d;
            mode_q      <= mode_d;
            prescale_q  <= prescale_d;
            stretch_q   <= stretch_d;
            tick_cnt_q  <= tick_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            act_cnt_q   <= act_cnt_d;
            out_q       <= out_d;
        end
    end

`ifdef LED_SEQ_PWM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bright_q  <= 8'hFF;
            pwm_cnt_q <= 8'd0;
            comp_q    <= '0;
        end else begin
            bright_q  <= bright_d;
            pwm_cnt_q <= pwm_cnt_d;
            comp_q    <= comp_d;
        end
    end
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[NUM_LEDS-1:0]   = direct_q;
            2'd1: readdata[2*NUM_LEDS-1:0] = mode_q;
            2'd2: begin
                readdata[15:0] = prescale_q;
`ifdef LED_SEQ_PWM_EN
                readdata[23:16] = bright_q;
`endif
            end
            default: begin
                readdata[7:0]           = stretch_q;
                readdata[16 +: NUM_LEDS] = out_q;
            end
        endcase
    end

    assign out_port = out_q;

endmodule
`default_nettype wire

// File: tb/tb_wasca_led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wasca_led_sequencer
//  Description : Self-checking bench for wasca_led_sequencer with a
//                behavioural reference model (tick/blink/stretch rules).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wasca_led_sequencer;

    localparam int N              = 5;
    localparam int PRESCALE_RESET = 49999;
    localparam int BLINK_TICKS    = 250;
    localparam int STRETCH_RESET  = 10;
`ifdef LED_SEQ_PWM_EN
    localparam int          LAT            = 2;
    localparam logic [31:0] PRESC_RD_RESET = 32'h00FF0000 | PRESCALE_RESET;
`else
    localparam int          LAT            = 1;
    localparam logic [31:0] PRESC_RD_RESET = PRESCALE_RESET;
`endif

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic [1:0]    address    = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n    = 1'b1;
    logic [31:0]   writedata  = 32'd0;
    logic [31:0]   readdata;
    logic [N-1:0]  act_in     = '0;
    logic [N-1:0]  out_port;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    wasca_led_sequencer #(
        .NUM_LEDS       (N),
        .PRESCALE_RESET (PRESCALE_RESET),
        .BLINK_TICKS    (BLINK_TICKS),
        .STRETCH_RESET  (STRETCH_RESET)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .act_in     (act_in),
        .out_port   (out_port)
    );

    // Reference model: ticks counted as cycles since last restart, blink phase
    // derived from the total tick count, stretch as remaining-ticks integers.
    logic [31:0]  m_direct, m_mode, m_prescale, m_stretch, m_bright;
    int           m_since, m_ticks, m_cycles;
    int           m_rem [N];
    logic [N-1:0] m_h1, m_h2, m_h3, m_out, m_comp;

    task automatic model_reset();
        m_direct   = 0;
        m_mode     = 0;
        m_prescale = PRESCALE_RESET;
        m_stretch  = STRETCH_RESET;
`ifdef LED_SEQ_PWM_EN
        m_bright   = 255;
`else
        m_bright   = 0;
`endif
        m_since = 0; m_ticks = 0; m_cycles = 0;
        for (int i = 0; i < N; i++) m_rem[i] = 0;
        m_h1 = '0; m_h2 = '0; m_h3 = '0; m_out = '0; m_comp = '0;
    endtask

    function automatic logic [N-1:0] model_composite();
        logic [N-1:0] c;
        logic         ph;
        logic         d;
        logic         a;
        ph = ((m_ticks / BLINK_TICKS) % 2) == 1;
        c  = '0;
        for (int i = 0; i < N; i++) begin
            d = m_direct[i];
            a = m_rem[i] > 0;
            case (m_mode[2*i +: 2])
                2'd0:    c[i] = d;
                2'd1:    c[i] = d && ph;
                2'd2:    c[i] = d || a;
                default: c[i] = a ? ph : d;
            endcase
        end
        return c;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            2'd0: r = m_direct;
            2'd1: r = m_mode;
            2'd2: r = m_prescale | (m_bright << 16);
            default: begin
                r = m_stretch;
                r[16 +: N] = m_out;
            end
        endcase
        return r;
    endfunction

    task automatic model_step();
        logic [N-1:0] comp, edge_v;
        logic         pwr, tk, gate, wr;
        if (!reset_n) begin
            model_reset();
            return;
        end
        comp = model_composite();
        wr   = chipselect && !write_n;
        pwr  = wr && (address == 2'd2);
        tk   = (m_since == int'(m_prescale)) && !pwr;
`ifdef LED_SEQ_PWM_EN
        gate   = (m_bright == 255) || ((m_cycles % 256) < int'(m_bright));
        m_out  = gate ? m_comp : '0;
        m_comp = comp;
`else
        gate  = 1'b1;
        m_out = gate ? comp : '0;
`endif
        m_cycles++;
        edge_v = m_h2 & ~m_h3;
        for (int i = 0; i < N; i++) begin
            if (edge_v[i] && m_stretch != 0) m_rem[i] = int'(m_stretch);
            else if (tk && m_rem[i] > 0)     m_rem[i] = m_rem[i] - 1;
        end
        if (tk) m_ticks++;
        m_since = (pwr || tk) ? 0 : m_since + 1;
        m_h3 = m_h2; m_h2 = m_h1; m_h1 = act_in;
        if (wr) begin
            case (address)
                2'd0: m_direct   = writedata & ((32'd1 << N) - 1);
                2'd1: m_mode     = writedata & ((32'd1 << (2*N)) - 1);
                2'd2: begin
                    m_prescale = writedata & 32'hFFFF;
`ifdef LED_SEQ_PWM_EN
                    m_bright   = (writedata >> 16) & 32'hFF;
`endif
                end
                default: m_stretch = writedata & 32'hFF;
            endcase
        end
    endtask

    // Every clock edge goes through here so the model never drifts
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        cyc();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic do_reset();
        chipselect = 1'b0; write_n = 1'b1; act_in = '0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp_v [4];
        exp_v = '{32'd0, 32'd0, PRESC_RD_RESET, 32'(STRETCH_RESET)};
        do_reset();
        tests_run++;
        if (out_port !== '0) begin
            tests_failed++;
            $display("FAIL reset_out: got %h, expected 0", out_port);
        end
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            tests_run++;
            if (rd !== exp_v[a]) begin
                tests_failed++;
                $display("FAIL reset_reg[%0d]: got %h, expected %h", a, rd, exp_v[a]);
            end
        end
    endtask

    task automatic test_direct();
        logic [31:0] rd;
        do_reset();
        bus_write(2'd0, 32'h15);
        for (int k = 1; k < LAT; k++) cyc();
        tests_run++;
        if (out_port !== 5'h00) begin
            tests_failed++;
            $display("FAIL direct_early: got %h, expected 00", out_port);
        end
        cyc();
        tests_run++;
        if (out_port !== 5'h15) begin
            tests_failed++;
            $display("FAIL direct_value: got %h, expected 15", out_port);
        end
        bus_read(2'd3, rd);
        tests_run++;
        if (rd !== (32'h00150000 | STRETCH_RESET)) begin
            tests_failed++;
            $display("FAIL direct_readback: got %h, expected %h", rd, 32'h00150000 | STRETCH_RESET);
        end
        // All LEDs to blink while phase is still off
        bus_write(2'd1, 32'h155);
        repeat (LAT) cyc();
        tests_run++;
        if (out_port !== 5'h00) begin
            tests_failed++;
            $display("FAIL mode_change: got %h, expected 00", out_port);
        end
    endtask

    task automatic test_blink();
        int n, h, l, others;
        do_reset();
        bus_write(2'd2, 32'd0);
        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'd1);
        cyc();
        tests_run++;
        if (out_port !== 5'h00) begin
            tests_failed++;
            $display("FAIL blink_start_off: got %h, expected 00", out_port);
        end
        n = 0; h = 0; l = 0; others = 0;
        while (out_port[0] !== 1'b1 && n < 600) begin
            cyc(); n++;
            if (out_port[N-1:1] !== '0) others++;
        end
        while (out_port[0] === 1'b1 && h < 600) begin
            cyc(); h++;
            if (out_port[N-1:1] !== '0) others++;
        end
        while (out_port[0] === 1'b0 && l < 600) begin
            cyc(); l++;
            if (out_port[N-1:1] !== '0) others++;
        end
        tests_run++;
        if (n >= 600 || h != BLINK_TICKS || l != BLINK_TICKS) begin
            tests_failed++;
            $display("FAIL blink_period: got rise_wait=%0d high=%0d low=%0d, expected high=low=%0d",
                     n, h, l, BLINK_TICKS);
        end
        tests_run++;
        if (others != 0) begin
            tests_failed++;
            $display("FAIL blink_others: got %0d cycles with other LEDs on, expected 0", others);
        end
    endtask

    task automatic test_activity();
        int   d, h, rises;
        logic last;
        do_reset();
        bus_write(2'd2, 32'd3);
        bus_write(2'd3, 32'd4);
        bus_write(2'd1, 32'h20);
        bus_write(2'd0, 32'd0);
        act_in[2] = 1'b1; cyc(); act_in[2] = 1'b0;
        d = 0;
        while (out_port[2] !== 1'b1 && d < 20) begin cyc(); d++; end
        tests_run++;
        if (d != 2 + LAT) begin
            tests_failed++;
            $display("FAIL act_latency: got %0d clk, expected %0d", d, 2 + LAT);
        end
        h = 0;
        while (out_port[2] === 1'b1 && h < 40) begin
            cyc(); h++;
            tests_run++;
            if (out_port !== m_out) begin
                tests_failed++;
                $display("FAIL act_model: got %h, expected %h", out_port, m_out);
            end
        end
        h = h + 1;
        tests_run++;
        if (h < 13 || h > 16) begin
            tests_failed++;
            $display("FAIL act_high_time: got %0d clk, expected 13..16", h);
        end
        // Retrigger: second pulse while still stretched
        repeat (4) cyc();
        act_in[2] = 1'b1; cyc(); act_in[2] = 1'b0;
        h = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 5) act_in[2] = 1'b1;
            else if (k == 6) act_in[2] = 1'b0;
            cyc();
            if (out_port[2] === 1'b1) h++;
            tests_run++;
            if (out_port !== m_out) begin
                tests_failed++;
                $display("FAIL retrig_model: got %h, expected %h", out_port, m_out);
            end
        end
        tests_run++;
        if (h < 19 || h > 22) begin
            tests_failed++;
            $display("FAIL retrig_high_time: got %0d clk, expected 19..22", h);
        end
        // STRETCH=0 ignores edges
        bus_write(2'd3, 32'd0);
        act_in[2] = 1'b1; cyc(); act_in[2] = 1'b0;
        h = 0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (out_port[2] === 1'b1) h++;
        end
        tests_run++;
        if (h != 0) begin
            tests_failed++;
            $display("FAIL stretch_zero: got %0d high clk, expected 0", h);
        end
        // Held-high input fires once
        bus_write(2'd3, 32'd4);
        act_in[2] = 1'b1;
        rises = 0; last = out_port[2];
        for (int k = 0; k < 60; k++) begin
            cyc();
            if (out_port[2] === 1'b1 && last === 1'b0) rises++;
            last = out_port[2];
        end
        act_in[2] = 1'b0;
        tests_run++;
        if (rises != 1 || out_port[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL act_held: got rises=%0d final=%b, expected rises=1 final=0", rises, out_port[2]);
        end
    endtask

    task automatic test_prescale_write();
        do_reset();
        bus_write(2'd1, 32'd2);
        bus_write(2'd3, 32'd1);
        act_in[0] = 1'b1; cyc(); act_in[0] = 1'b0;
        repeat (9990) cyc();
        tests_run++;
        if (out_port[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL prescale_hold: got %b, expected 1", out_port[0]);
        end
        bus_write(2'd2, 32'd1);
        repeat (LAT + 1) cyc();
        tests_run++;
        if (out_port[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL prescale_no_early_tick: got %b, expected 1", out_port[0]);
        end
        cyc();
        tests_run++;
        if (out_port[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL prescale_tick_2clk: got %b, expected 0", out_port[0]);
        end
    endtask

    task automatic test_brightness();
        logic [31:0] rd;
        int          h;
        do_reset();
`ifdef LED_SEQ_PWM_EN
        bus_write(2'd2, 32'h0040_0000);
        bus_write(2'd0, 32'd1);
        repeat (4) cyc();
        h = 0;
        for (int k = 0; k < 256; k++) begin cyc(); if (out_port[0] === 1'b1) h++; end
        tests_run++;
        if (h != 64) begin
            tests_failed++;
            $display("FAIL pwm_duty: got %0d of 256, expected 64", h);
        end
        bus_read(2'd2, rd);
        tests_run++;
        if (rd !== 32'h0040_0000) begin
            tests_failed++;
            $display("FAIL pwm_readback: got %h, expected 00400000", rd);
        end
        bus_write(2'd2, 32'd0);
        repeat (4) cyc();
        h = 0;
        for (int k = 0; k < 256; k++) begin cyc(); if (out_port !== '0) h++; end
        tests_run++;
        if (h != 0) begin
            tests_failed++;
            $display("FAIL pwm_bright_zero: got %0d on clk, expected 0", h);
        end
`else
        bus_write(2'd2, 32'h0040_0005);
        bus_read(2'd2, rd);
        tests_run++;
        if (rd !== 32'd5) begin
            tests_failed++;
            $display("FAIL bright_absent: got %h, expected 00000005", rd);
        end
        bus_write(2'd0, 32'd1);
        h = 0;
        for (int k = 0; k < 64; k++) begin cyc(); if (out_port[0] !== 1'b1) h++; end
        tests_run++;
        if (h != 0) begin
            tests_failed++;
            $display("FAIL no_gating: got %0d off clk, expected 0", h);
        end
`endif
    endtask

    task automatic test_reset_midrun();
        logic [31:0] rd;
        logic [31:0] exp_v [4];
        int          n;
        exp_v = '{32'd0, 32'd0, PRESC_RD_RESET, 32'(STRETCH_RESET)};
        do_reset();
        bus_write(2'd2, 32'd0);
        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'd1);
        n = 0;
        while (out_port[0] !== 1'b1 && n < 600) begin cyc(); n++; end
        tests_run++;
        if (n >= 600) begin
            tests_failed++;
            $display("FAIL midrun_blink_timeout: got no blink in %0d clk, expected < 600", n);
        end
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (out_port !== '0) begin
            tests_failed++;
            $display("FAIL midrun_async_clear: got %h, expected 0", out_port);
        end
        cyc();
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            tests_run++;
            if (rd !== exp_v[a]) begin
                tests_failed++;
                $display("FAIL midrun_reg[%0d]: got %h, expected %h", a, rd, exp_v[a]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] expd;
        logic [1:0]  ra;
        do_reset();
        bus_write(2'd2, $urandom_range(0, 2));
        bus_write(2'd3, $urandom_range(1, 6));
        bus_write(2'd1, $urandom);
        bus_write(2'd0, $urandom);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) act_in = N'($urandom);
            if ($urandom_range(0, 24) == 0) begin
                chipselect = 1'b1; write_n = 1'b0;
                address    = 2'($urandom);
                writedata  = $urandom;
                if (address == 2'd2) writedata = (writedata & 32'hFFFF0000) | $urandom_range(0, 3);
                if (address == 2'd3) writedata[7:0] = 8'($urandom_range(0, 8));
            end
            cyc();
            chipselect = 1'b0; write_n = 1'b1;
            tests_run++;
            if (out_port !== m_out) begin
                tests_failed++;
                $display("FAIL rand_out[%0d]: got %h, expected %h", c, out_port, m_out);
            end
            ra      = 2'($urandom);
            address = ra;
            #1;
            expd = model_read(ra);
            tests_run++;
            if (readdata !== expd) begin
                tests_failed++;
                $display("FAIL rand_read[%0d] addr %0d: got %h, expected %h", c, ra, readdata, expd);
            end
        end
        act_in = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_direct();
        test_blink();
        test_activity();
        test_prescale_write();
        test_brightness();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/wasca_led_sequencer.md
Name: wasca_led_sequencer

Overview:
- Avalon-MM slave that drives the board status LEDs.
- Replaces raw PIO writes with per-LED modes: direct, blink, activity pulse-stretch, and blink-while-active.
- Activity inputs come from bus/flash/SD logic and are shared onto the same LED outputs.
- Sits on the Nios-side Avalon bus; out_port goes straight to the LED pins.

Parameters:
- NUM_LEDS, 5, number of LED outputs and activity inputs (1..8).
- PRESCALE_RESET, 49999, reset value of PRESCALE register (tick every PRESCALE+1 clk).
- BLINK_TICKS, 250, ticks per blink half-period.
- STRETCH_RESET, 10, reset value of STRETCH register (ticks).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  2  Avalon register index
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, combinational from address
- act_in  in  NUM_LEDS  asynchronous activity requests, one per LED
- out_port  out  NUM_LEDS  LED drive, registered

Behaviour:
- Reset is asynchronous and active-low (reset_n); clock is clk. All state below is cleared/loaded asynchronously on reset_n low.
- Register map (write when chipselect && !write_n; reads zero-wait, unused bits read 0):
  - addr 0 DIRECT: [NUM_LEDS-1:0] RW, reset 0.
  - addr 1 MODE: 2 bits per LED, LED i at [2i+1:2i], RW, reset 0. Encoding: 00 direct, 01 blink, 10 activity, 11 blink-while-active.
  - addr 2 PRESCALE: [15:0] RW, reset PRESCALE_RESET.
  - addr 3 STRETCH: [7:0] RW, reset STRETCH_RESET. Read also returns out_port at [23:16].
- Tick generator:
  - 16-bit down-counter; a 1-cycle tick fires when it reaches 0, then it reloads PRESCALE.
  - A write to PRESCALE reloads the counter immediately, with no tick that cycle.
  - PRESCALE=0 gives a tick every clk.
- Blink phase:
  - Tick counter 0..BLINK_TICKS-1; phase toggles on the tick that wraps it.
  - Phase resets to 0 (LED off); one phase is shared by all LEDs.
- Activity, per LED:
  - act_in passes through a 2-FF synchronizer, then rising-edge detect.
  - An edge loads an 8-bit stretch counter with STRETCH; the counter decrements on each tick while nonzero.
  - active = counter != 0.
  - An edge while nonzero reloads the counter (retrigger).
  - Edge and tick in the same cycle: the load wins.
  - STRETCH=0: edges are ignored.
- Composite per LED:
  - direct: DIRECT[i]
  - blink: DIRECT[i] & phase
  - activity: DIRECT[i] | active
  - blink-while-active: active ? phase : DIRECT[i]
- out_port is registered from the composite, 1 clk latency. Reset value is 0.
- A MODE write takes effect on out_port 1 clk after the write cycle. Stretch counters are not cleared by mode changes.
- Address-decode only; no waitrequest; writes to out_port-readback bits are ignored.

Optional Feature:
- LED_SEQ_PWM_EN — global brightness.
- Defined:
  - PRESCALE[23:16] becomes BRIGHT, RW, reset 8'hFF.
  - An 8-bit free-running counter p increments every clk.
  - out_port = composite & (BRIGHT==8'hFF || p < BRIGHT).
  - BRIGHT=0 forces all LEDs off.
  - Adds 1 clk of latency (2 total).
- Undefined:
  - PRESCALE[23:16] reads 0; writes ignored.
  - No gating; latency 1 clk.

Test Plan:
- Reset mid-run: assert reset_n low while blinking -> out_port=0 asynchronously; registers read DIRECT=0, MODE=0, PRESCALE=49999, STRETCH=10.
- Direct mode: write DIRECT=5'h15 -> out_port=5'h15 exactly 1 clk after the write; read addr 3 returns 0x00150000 + STRETCH.
- Blink: PRESCALE=0, MODE=0x1 (LED0 blink), DIRECT=1 -> LED0 toggles every 250 clk starting off; other LEDs 0.
- Activity stretch: PRESCALE=3, STRETCH=4, MODE LED2=10, DIRECT=0; 1-clk pulse on act_in[2] -> LED2 high 3 clk after the pulse, stays high ~16 clk (4 ticks × 4 clk), then low.
- Retrigger/edge cases: second pulse while active -> counter reloads and high time extends; STRETCH=0 -> pulse leaves LED2 low; act_in held high -> single stretch only, no re-fire.
- PRESCALE write mid-count (LED_SEQ_PWM_EN off/on): write PRESCALE=1 while counter at 40000 -> next tick 2 clk later. With macro, BRIGHT=0x40 -> a LED that is on is high 64 of 256 clk; BRIGHT=0 -> all off.
